// File: rtl/clock_div_five.sv
`timescale 1ns/1ps
// Divide-by-five clock generator with 50% duty cycle.
// A mod-5 counter on the rising edge drives a phase flop that is high for
// two input cycles. A falling-edge copy of that flop extends the high phase
// by half a cycle. ORing the two gives 2.5 cycles high and 2.5 cycles low.
module clock_div_five (
    input  logic clk_in,
    input  logic rst,
    output logic clock_div_5
);

    logic [2:0] cnt_q;
    logic [2:0] cnt_d;
    logic       a_q;
    logic       a_d;
    logic       b_q;
    logic       b_d;

    // Next-state for the rising-edge domain: counter wrap and phase decode.
    // Values 5..7 should never occur, but they wrap to 0 just like 4 does.
    always_comb begin
        a_d   = (cnt_q == 3'd0) || (cnt_q == 3'd1);
        cnt_d = (cnt_q >= 3'd4) ? 3'd0 : cnt_q + 3'd1;
    end

    // The falling-edge flop copies the phase flop, delaying it by half a cycle.
    always_comb begin
        b_d = a_q;
    end

    // Rising-edge state with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            cnt_q <= 3'd0;
            a_q   <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            a_q   <= a_d;
        end
    end

    // Falling-edge retiming flop with synchronous reset.
    always_ff @(negedge clk_in) begin
        if (rst) begin
            b_q <= 1'b0;
        end else begin
            b_q <= b_d;
        end
    end

    // a and b change on opposite edges, so the OR cannot glitch.
    assign clock_div_5 = a_q | b_q;

endmodule

// File: tb/tb_clock_div_five.sv
`timescale 1ns/1ps
// Directed testbench for clock_div_five: reset behaviour, waveform shape,
// internal sequencing, mid-operation reset and long reset hold.
module tb_clock_div_five;

    logic clk_in;
    logic rst;
    logic clock_div_5;

    int   vectors;
    int   miscompares;
    int   rises;
    int   falls;
    time  last_rise;
    time  last_fall;
    time  e0;
    int   rises_snap;
    int   falls_snap;

    clock_div_five dut (
        .clk_in      (clk_in),
        .rst         (rst),
        .clock_div_5 (clock_div_5)
    );

    initial begin
        clk_in = 1'b1;
        forever #5 clk_in = ~clk_in;
    end

    // Edge monitors on the divided clock, used to detect glitches and measure edges.
    always @(posedge clock_div_5) begin
        rises     = rises + 1;
        last_rise = $time;
    end

    always @(negedge clock_div_5) begin
        falls     = falls + 1;
        last_fall = $time;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors = vectors + 1;
        assert (obs === exp) else begin
            miscompares = miscompares + 1;
            $error("FAIL %s @%0t: observed %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    task automatic at_pos();
        @(posedge clk_in);
        #2;
    endtask

    task automatic at_neg();
        @(negedge clk_in);
        #2;
    endtask

    // Called 2 ns after E0. Checks every half cycle against the expected
    // 5-high / 5-low half-period pattern and the internal sequence.
    task automatic run_check(input string tag, input int n_halves);
        int k;
        for (int h = 0; h < n_halves; h++) begin
            if (h > 0) begin
                if (h % 2 == 0) at_pos();
                else            at_neg();
            end
            k = h / 2;
            check({tag, "_out"}, {63'd0, clock_div_5}, {63'd0, ((h % 10) < 5)});
            if (h % 2 == 0) begin
                check({tag, "_cnt"}, {61'd0, dut.cnt_q}, 64'((k + 1) % 5));
                check({tag, "_a"}, {63'd0, dut.a_q}, {63'd0, ((k % 5) < 2)});
            end else begin
                check({tag, "_b"}, {63'd0, dut.b_q}, {63'd0, ((k % 5) < 2)});
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rises       = 0;
        falls       = 0;
        last_rise   = 0;
        last_fall   = 0;
        rst         = 1'b0;

        // Free-running without reset, then assert reset between edges.
        #101;
        rst = 1'b1;
        at_pos();
        at_neg();
        for (int i = 0; i < 18; i++) begin
            if (i > 0) begin
                if (i % 2 == 1) at_pos();
                else            at_neg();
            end
            check("rst_out", {63'd0, clock_div_5}, 64'd0);
            check("rst_cnt", {61'd0, dut.cnt_q}, 64'd0);
        end

        // Release after a falling edge; E0 is the next rising edge.
        at_neg();
        rst = 1'b0;
        rises_snap = rises;
        falls_snap = falls;
        @(posedge clk_in);
        e0 = $time;
        #2;
        run_check("run", 100);
        check("run_rises", 64'(rises - rises_snap), 64'd10);
        check("run_falls", 64'(falls - falls_snap), 64'd10);
        check("run_last_rise", 64'(last_rise), 64'(e0 + 450));
        check("run_last_fall", 64'(last_fall), 64'(e0 + 475));

        // Reset pulse while the output is high.
        at_pos();
        check("mid_high", {63'd0, clock_div_5}, 64'd1);
        at_neg();
        rst = 1'b1;
        rises_snap = rises;
        falls_snap = falls;
        check("mid_pre", {63'd0, clock_div_5}, 64'd1);
        at_pos();
        check("mid_a", {63'd0, dut.a_q}, 64'd0);
        check("mid_cnt", {61'd0, dut.cnt_q}, 64'd0);
        at_neg();
        check("mid_out", {63'd0, clock_div_5}, 64'd0);
        check("mid_b", {63'd0, dut.b_q}, 64'd0);
        rst = 1'b0;
        @(posedge clk_in);
        e0 = $time;
        #2;
        run_check("rel", 20);
        check("rel_rises", 64'(rises - rises_snap), 64'd2);
        check("rel_falls", 64'(falls - falls_snap), 64'd3);
        check("rel_last_rise", 64'(last_rise), 64'(e0 + 50));
        check("rel_last_fall", 64'(last_fall), 64'(e0 + 75));

        // Long reset hold: output and counter stay at zero with no edges.
        rst = 1'b1;
        at_pos();
        at_neg();
        rises_snap = rises;
        falls_snap = falls;
        for (int i = 0; i < 40; i++) begin
            if (i % 2 == 0) at_pos();
            else            at_neg();
            check("hold_out", {63'd0, clock_div_5}, 64'd0);
            check("hold_cnt", {61'd0, dut.cnt_q}, 64'd0);
        end
        check("hold_rises", 64'(rises - rises_snap), 64'd0);
        check("hold_falls", 64'(falls - falls_snap), 64'd0);

        // Release once more and confirm the pattern restarts at E0.
        rst = 1'b0;
        @(posedge clk_in);
        e0 = $time;
        #2;
        run_check("again", 10);
        check("again_rise", 64'(last_rise), 64'(e0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/clock_div_five.md
Name: clock_div_five

Overview:
Divide-by-five clock generator producing a 50% duty-cycle output from a single input clock. It uses a posedge-domain mod-5 counter plus a half-cycle (negedge) retiming flop to get the 2.5-cycle high phase. The output is a derived clock/enable source for slower logic elsewhere in the design.

Parameters:
None. The divide ratio is fixed at 5.

Ports:
clk_in  input  1  source clock; all state is referenced to this single clock (rising and falling edges)
rst  input  1  reset, synchronous and active-high, sampled on clk_in edges
clock_div_5  output  1  divided clock; period = 5 clk_in periods, high for 2.5 periods

Behaviour:
- One clock, clk_in. Reset is synchronous and active-high. No asynchronous reset path.
- State elements:
  - cnt: 3-bit counter, posedge clk_in.
  - a: 1-bit phase flop, posedge clk_in.
  - b: 1-bit retiming flop, negedge clk_in.
- Posedge clk_in, rst=1: cnt<=0, a<=0.
- Posedge clk_in, rst=0:
  - a <= (cnt==0 || cnt==1), using the current cnt.
  - cnt <= (cnt==4) ? 0 : cnt+1.
- Negedge clk_in, rst=1: b<=0.
- Negedge clk_in, rst=0: b<=a.
- clock_div_5 = a | b (combinational OR of two flop outputs; glitch-free because a and b change on opposite edges).
- cnt sequence: 0,1,2,3,4,0,... Values 5–7 are unreachable; if one is ever present, it wraps to 0 on the next non-reset posedge (use ">=4" for the wrap compare).
- Timing after reset release. Let E0 be the first posedge sampling rst=0, and T the clk_in period.
  - clock_div_5 rises at E0.
  - It falls at E0+2.5T.
  - It rises again at E0+5T, then repeats.
- Steady state: period 5T, high time exactly 2.5T, low time exactly 2.5T (50% duty).
- During reset: clock_div_5=0 once a posedge and the following negedge have both sampled rst=1.
- Reset mid-operation:
  - a clears at the first posedge sampling rst=1.
  - b clears at the next negedge.
  - Output is 0 no later than 0.5T after that posedge.
  - No partial or short high pulses after that point.
- Before the first reset, register contents are not guaranteed. Reset must be applied at least one full clk_in period before the output is used.
- Reset held for many cycles: output stays 0, cnt stays 0.
- Latency from reset deassertion to first rising output edge: 0 cycles (rises at E0).

Test Plan:
- Clock 10 ns period (toggle every 5 ns, start high). Hold rst=0 for 100 ns, then assert rst=1 for 100 ns -> clock_div_5=0 throughout the reset window once two edges have sampled rst=1; cnt=0.
- Release rst at a negedge before posedge E0 -> clock_div_5 rises at E0, falls at E0+25 ns, rises at E0+50 ns.
- Run 500 ns after release -> 10 full output periods. Every period is 50 ns, every high phase is 25 ns, and there are no glitches between edges.
- Internal sequence check: cnt = 0,1,2,3,4,0 on consecutive posedges after release. a is high for exactly 2 of every 5 posedge intervals. b equals a delayed by 5 ns.
- Assert rst=1 for one posedge while clock_div_5 is high (e.g. E0+10 ns) -> output is 0 by the following negedge. After release, the first rising edge occurs at the first posedge sampling rst=0, and the 25/25 ns pattern restarts.
- Hold rst=1 for 20 cycles -> output constant 0, with no toggling on either clock edge.
